// File: rtl/serdes_pkg.sv
// Shared types for the deserializer link-training controller.
// Debug/CSR state encoding and word width of the 1-bit->10-bit deserializer.
package serdes_pkg;

  localparam int WORD_W = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RST    = 3'd1,
    ALIGN  = 3'd2,
    SETTLE = 3'd3,
    LOCKED = 3'd4,
    FAIL   = 3'd5
  } ctrl_state_e;

endpackage

// File: rtl/serdes_err_monitor.sv
// Symbol-error monitor: counts errored words per fixed-size word window.
// Latency: lost is combinational on the word that reaches the threshold.
// Backpressure: none; every word_stb is consumed, clr holds counters at zero.
module serdes_err_monitor #(
  parameter int ERR_WIN    = 64,
  parameter int ERR_THRESH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic word_stb,
  input  logic sym_err,
  output logic lost
);

  localparam int WW = $clog2(ERR_WIN) + 1;
  localparam int EW = $clog2(ERR_THRESH) + 1;

  logic [WW-1:0] win_cnt;
  logic [EW-1:0] err_cnt;
  logic [EW-1:0] err_inc;
  logic          win_last;

  // The error on the closing word of a window is counted before the window clears.
  assign err_inc  = err_cnt + EW'(sym_err);
  assign win_last = (win_cnt == WW'(ERR_WIN - 1));
  assign lost     = !clr && word_stb && sym_err && (err_inc == EW'(ERR_THRESH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt <= '0;
      err_cnt <= '0;
    end else if (clr) begin
      win_cnt <= '0;
      err_cnt <= '0;
    end else if (word_stb) begin
      if (win_last) begin
        win_cnt <= '0;
        err_cnt <= '0;
      end else begin
        win_cnt <= win_cnt + WW'(1);
        err_cnt <= err_inc;
      end
    end
  end

endmodule

// File: rtl/serdes_link_ctrl.sv
// Link-training controller: reset/enable the deserializer, align, settle, lock, monitor.
// Latency: every output is a flop loaded from next-state decode (one edge after the cause).
// Backpressure: none; start is only honoured in IDLE/FAIL, stop aborts from anywhere.
module serdes_link_ctrl
  import serdes_pkg::*;
#(
  parameter int RST_CYC      = 8,
  parameter int ALIGN_TO     = 4096,
  parameter int MAX_RETRY    = 3,
  parameter int SETTLE_WORDS = 2,
  parameter int ERR_WIN      = 64,
  parameter int ERR_THRESH   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           des_bit_align_done,
  input  logic                           word_stb,
  input  logic                           sym_err,
  output logic                           des_rst_n,
  output logic                           des_enable,
  output logic                           link_up,
  output logic                           train_fail,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt,
  output ctrl_state_e                    state
);

  localparam int RW   = $clog2(MAX_RETRY + 1);
  localparam int RC_W = $clog2(RST_CYC) + 1;
  localparam int TM_W = $clog2(ALIGN_TO) + 1;
  localparam int SW_W = $clog2(SETTLE_WORDS) + 1;

  ctrl_state_e   state_nx;
  logic [RC_W-1:0] rst_cnt, rst_cnt_nx;
  logic [TM_W-1:0] timer, timer_nx;
  logic [SW_W-1:0] wcnt, wcnt_nx;
  logic [RW-1:0]   retry_nx;
  logic            timeout;
  logic            run_nx;
  logic            lost;

  serdes_err_monitor #(
    .ERR_WIN   (ERR_WIN),
    .ERR_THRESH(ERR_THRESH)
  ) u_err_mon (
    .clk     (clk),
    .rst     (rst),
    .clr     (state != LOCKED),
    .word_stb(word_stb),
    .sym_err (sym_err),
    .lost    (lost)
  );

  // ALIGN and SETTLE share one budget; >= keeps an alignment on the last cycle from wrapping.
  assign timeout = (timer >= TM_W'(ALIGN_TO - 1));
  assign run_nx  = (state_nx == ALIGN) || (state_nx == SETTLE) || (state_nx == LOCKED);

  always_comb begin
    state_nx   = state;
    rst_cnt_nx = rst_cnt;
    timer_nx   = timer;
    wcnt_nx    = wcnt;
    retry_nx   = retry_cnt;
    if (stop) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE, FAIL: begin
          if (start) begin
            state_nx   = RST;
            rst_cnt_nx = '0;
            retry_nx   = '0;
          end
        end
        RST: begin
          if (rst_cnt == RC_W'(RST_CYC - 1)) begin
            state_nx = ALIGN;
            timer_nx = '0;
          end else begin
            rst_cnt_nx = rst_cnt + RC_W'(1);
          end
        end
        ALIGN, SETTLE: begin
          timer_nx = timer + TM_W'(1);
          if (state == ALIGN && des_bit_align_done) begin
            state_nx = SETTLE;
            wcnt_nx  = '0;
          end else if (state == SETTLE && word_stb && wcnt == SW_W'(SETTLE_WORDS - 1)) begin
            state_nx = LOCKED;
            retry_nx = '0;
          end else begin
            if (state == SETTLE && word_stb) wcnt_nx = wcnt + SW_W'(1);
            if (timeout) begin
              if (retry_cnt == RW'(MAX_RETRY)) begin
                state_nx = FAIL;
              end else begin
                state_nx   = RST;
                rst_cnt_nx = '0;
                retry_nx   = retry_cnt + RW'(1);
              end
            end
          end
        end
        LOCKED: begin
          retry_nx = '0;
          if (lost) begin
            state_nx   = RST;
            rst_cnt_nx = '0;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rst_cnt    <= '0;
      timer      <= '0;
      wcnt       <= '0;
      retry_cnt  <= '0;
      des_rst_n  <= 1'b0;
      des_enable <= 1'b0;
      link_up    <= 1'b0;
      train_fail <= 1'b0;
    end else begin
      state      <= state_nx;
      rst_cnt    <= rst_cnt_nx;
      timer      <= timer_nx;
      wcnt       <= wcnt_nx;
      retry_cnt  <= retry_nx;
      des_rst_n  <= run_nx;
      des_enable <= run_nx;
      link_up    <= (state_nx == LOCKED);
      train_fail <= (state_nx == FAIL);
    end
  end

endmodule

// File: tb/tb_serdes_link_ctrl.sv
// Directed bench for serdes_link_ctrl with small timeout (ALIGN_TO=64) for fast retries.
module tb_serdes_link_ctrl;
  import serdes_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        des_bit_align_done = 1'b0;
  logic        word_stb = 1'b0;
  logic        sym_err = 1'b0;
  logic        des_rst_n;
  logic        des_enable;
  logic        link_up;
  logic        train_fail;
  logic [1:0]  retry_cnt;
  ctrl_state_e state;

  int errors = 0;
  int checks = 0;

  serdes_link_ctrl #(
    .RST_CYC(8), .ALIGN_TO(64), .MAX_RETRY(3), .SETTLE_WORDS(2), .ERR_WIN(64), .ERR_THRESH(4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .stop              (stop),
    .des_bit_align_done(des_bit_align_done),
    .word_stb          (word_stb),
    .sym_err           (sym_err),
    .des_rst_n         (des_rst_n),
    .des_enable        (des_enable),
    .link_up           (link_up),
    .train_fail        (train_fail),
    .retry_cnt         (retry_cnt),
    .state             (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ticks until des_rst_n reaches lvl; a budget overrun returns budget.
  task automatic wait_rstn(input logic lvl, input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (des_rst_n !== lvl && n < budget);
  endtask

  // Sends n words (one idle cycle between); stops at the first word after which link_up is low.
  task automatic send_words(input int n, input logic [63:0] emask,
                            output int drop_at, output logic rstn_at);
    drop_at = 0;
    rstn_at = 1'b1;
    for (int w = 1; w <= n; w++) begin
      word_stb = 1'b1;
      sym_err  = emask[w-1];
      tick();
      word_stb = 1'b0;
      sym_err  = 1'b0;
      if (!link_up) begin
        drop_at = w;
        rstn_at = des_rst_n;
        return;
      end
      tick();
    end
  endtask

  task automatic relock();
    des_bit_align_done = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) begin
      word_stb = 1'b1;
      tick();
      word_stb = 1'b0;
      tick();
    end
  endtask

  initial begin
    int          n;
    int          drop;
    logic        rstn_at;
    logic [63:0] m;

    // Reset state
    #12;
    chk("rst_state", state, IDLE);
    chk("rst_des_rst_n", des_rst_n, 1'b0);
    chk("rst_des_enable", des_enable, 1'b0);
    chk("rst_link_up", link_up, 1'b0);
    chk("rst_train_fail", train_fail, 1'b0);
    chk("rst_retry", retry_cnt, 2'd0);
    @(negedge clk) rst = 1'b0;
    tick();

    // 1: normal lock
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_state_rst", state, RST);
    wait_rstn(1'b1, 40, n);
    chk("t1_rst_len", n, 8);
    chk("t1_state_align", state, ALIGN);
    chk("t1_enable", des_enable, 1'b1);
    repeat (19) tick();
    des_bit_align_done = 1'b1;
    tick();
    chk("t1_state_settle", state, SETTLE);
    word_stb = 1'b1;
    tick();
    word_stb = 1'b0;
    chk("t1_link_after_1st", link_up, 1'b0);
    tick();
    word_stb = 1'b1;
    tick();
    word_stb = 1'b0;
    chk("t1_link_up", link_up, 1'b1);
    chk("t1_state_locked", state, LOCKED);
    chk("t1_retry", retry_cnt, 2'd0);

    // 3: loss of lock; unqualified sym_err must not count
    sym_err = 1'b1;
    repeat (5) tick();
    sym_err = 1'b0;
    chk("t3_unqualified_err", link_up, 1'b1);
    m = '0;
    m[4] = 1'b1; m[8] = 1'b1; m[29] = 1'b1; m[30] = 1'b1;
    send_words(31, m, drop, rstn_at);
    chk("t3_drop_word", drop, 31);
    chk("t3_drop_rstn", rstn_at, 1'b0);
    chk("t3_state_rst", state, RST);
    des_bit_align_done = 1'b0;
    wait_rstn(1'b1, 40, n);
    chk("t3_retrain_rst_len", n, 8);
    relock();
    chk("t3_relocked", link_up, 1'b1);

    // 4: window boundaries
    for (int win = 1; win <= 5; win++) begin
      m = '0;
      if (win % 2 == 1) begin m[61] = 1'b1; m[62] = 1'b1; m[63] = 1'b1; end
      else begin m[0] = 1'b1; m[1] = 1'b1; m[2] = 1'b1; end
      send_words(64, m, drop, rstn_at);
      chk($sformatf("t4_window%0d_hold", win), drop, 0);
    end
    m = '0;
    m[60] = 1'b1; m[61] = 1'b1; m[62] = 1'b1; m[63] = 1'b1;
    send_words(64, m, drop, rstn_at);
    chk("t4_last_word_drop", drop, 64);
    chk("t4_last_word_rstn", rstn_at, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    des_bit_align_done = 1'b0;
    chk("t4_stop_idle", state, IDLE);
    chk("t4_stop_rstn", des_rst_n, 1'b0);

    // 2: timeout and retries
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int a = 0; a < 4; a++) begin
      wait_rstn(1'b1, 40, n);
      chk($sformatf("t2_rst_len%0d", a), n, 8);
      chk($sformatf("t2_retry%0d", a), retry_cnt, a);
      wait_rstn(1'b0, 100, n);
      chk($sformatf("t2_align_len%0d", a), n, 64);
    end
    chk("t2_state_fail", state, FAIL);
    chk("t2_train_fail", train_fail, 1'b1);
    chk("t2_retry_final", retry_cnt, 2'd3);
    chk("t2_enable_off", des_enable, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t2_restart_fail_clr", train_fail, 1'b0);
    chk("t2_restart_retry_clr", retry_cnt, 2'd0);
    chk("t2_restart_state", state, RST);

    // 5a: alignment on the timeout cycle
    wait_rstn(1'b1, 40, n);
    chk("t5_rst_len", n, 8);
    repeat (63) tick();
    des_bit_align_done = 1'b1;
    tick();
    chk("t5_align_wins", state, SETTLE);
    chk("t5_retry_kept", retry_cnt, 2'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    des_bit_align_done = 1'b0;

    // 5b: start and stop together in LOCKED
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_rstn(1'b1, 40, n);
    relock();
    chk("t5_locked", state, LOCKED);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    des_bit_align_done = 1'b0;
    chk("t5_stop_wins", state, IDLE);
    chk("t5_stop_link", link_up, 1'b0);

    // 6: asynchronous reset mid-ALIGN
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_rstn(1'b1, 40, n);
    repeat (10) tick();
    chk("t6_in_align", state, ALIGN);
    #3 rst = 1'b1;
    #1;
    chk("t6_state", state, IDLE);
    chk("t6_des_rst_n", des_rst_n, 1'b0);
    chk("t6_des_enable", des_enable, 1'b0);
    chk("t6_link_up", link_up, 1'b0);
    chk("t6_train_fail", train_fail, 1'b0);
    chk("t6_retry", retry_cnt, 2'd0);
    @(negedge clk) rst = 1'b0;
    tick();
    chk("t6_idle_after", state, IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
